// File: rtl/plot_scheduler.sv
// Frame scheduler sharing one VGA write port among N_REQ sprite plotters.
// Grants snapshotted requests one at a time, lowest index first (highest index drawn on top).
module plot_scheduler #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 1023,
  parameter int TW      = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frame_tick,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ-1:0]     done,
  input  logic [9*N_REQ-1:0]   x_in,
  input  logic [8*N_REQ-1:0]   y_in,
  input  logic [3*N_REQ-1:0]   colour_in,
  output logic [N_REQ-1:0]     grant,
  output logic [8:0]           x_out,
  output logic [7:0]           y_out,
  output logic [2:0]           colour_out,
  output logic                 vga_write,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 timeout_err,
  output logic                 overrun
);

  localparam int SW = $clog2(N_REQ);

  typedef enum logic [2:0] {IDLE, SCAN, GRANT, GAP, FINISH} state_t;

  state_t            state;
  logic [N_REQ-1:0]  pending;
  logic [SW-1:0]     sel;
  logic [SW-1:0]     low_idx;
  logic [TW-1:0]     timer;

  // Priority encoder: scanning downwards leaves the lowest set index.
  always_comb begin
    low_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (pending[i]) low_idx = SW'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pending     <= '0;
      sel         <= '0;
      timer       <= '0;
      grant       <= '0;
      vga_write   <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      timeout_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (frame_tick && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (frame_tick) begin
            pending <= req;
            busy    <= 1'b1;
            state   <= SCAN;
          end
        end
        SCAN: begin
          if (pending == '0) begin
            frame_done <= 1'b1;
            state      <= FINISH;
          end else begin
            sel              <= low_idx;
            pending[low_idx] <= 1'b0;
            timer            <= '0;
            grant            <= N_REQ'(1) << low_idx;
            vga_write        <= 1'b1;
            state            <= GRANT;
          end
        end
        GRANT: begin
          timer <= timer + 1'b1;
          // done wins over a timeout landing in the same cycle.
          if (done[sel]) begin
            grant     <= '0;
            vga_write <= 1'b0;
            state     <= GAP;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            grant       <= '0;
            vga_write   <= 1'b0;
            state       <= GAP;
          end
        end
        GAP: state <= SCAN;
        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          grant     <= '0;
          vga_write <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  // Pixel data passes straight through from the granted plotter.
  always_comb begin
    x_out      = '0;
    y_out      = '0;
    colour_out = '0;
    if (state == GRANT) begin
      x_out      = x_in[9*int'(sel) +: 9];
      y_out      = y_in[8*int'(sel) +: 8];
      colour_out = colour_in[3*int'(sel) +: 3];
    end
  end

endmodule

// File: tb/tb_plot_scheduler.sv
// Directed bench for plot_scheduler: empty frame, single grant, ordering,
// timeout, overrun/stray done, and reset during a grant.
module tb_plot_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_tick;
  logic [3:0]  req;
  logic [3:0]  done;
  logic [35:0] x_in;
  logic [31:0] y_in;
  logic [11:0] colour_in;
  logic [3:0]  grant;
  logic [8:0]  x_out;
  logic [7:0]  y_out;
  logic [2:0]  colour_out;
  logic        vga_write, busy, frame_done, timeout_err, overrun;

  int errors = 0;
  int checks = 0;

  logic [3:0] rec [0:2047];
  int         rec_n;
  int         fd_seen;
  int         gcnt;
  logic [3:0] exp3 [0:13];

  always #5 clk = ~clk;

  plot_scheduler #(.N_REQ(4), .TIMEOUT(1023), .TW(10)) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .req(req), .done(done),
    .x_in(x_in), .y_in(y_in), .colour_in(colour_in), .grant(grant),
    .x_out(x_out), .y_out(y_out), .colour_out(colour_out), .vga_write(vga_write),
    .busy(busy), .frame_done(frame_done), .timeout_err(timeout_err), .overrun(overrun)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Starts a frame and records grant each cycle until frame_done; a granted
  // plotter pulses done on its len-th cycle (len=0 means never).
  task automatic run_frame(input logic [3:0] r, input int len);
    int run;
    rec_n = 0;
    fd_seen = 0;
    run = 0;
    req = r;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    for (int c = 0; c < 2000 && fd_seen == 0; c++) begin
      rec[rec_n] = grant;
      rec_n++;
      if (frame_done) fd_seen = 1;
      if (grant != 4'b0) begin
        run++;
        done = (run == len) ? grant : 4'b0;
      end else begin
        run = 0;
        done = 4'b0;
      end
      step();
    end
    done = 4'b0;
    check("frame_done_seen", fd_seen, 1);
  endtask

  initial begin
    reset = 1'b1; frame_tick = 1'b0; req = 4'b0; done = 4'b0;
    x_in = {9'd400, 9'd300, 9'd200, 9'd100};
    y_in = {8'd44, 8'd33, 8'd22, 8'd11};
    colour_in = {3'd7, 3'd5, 3'd3, 3'd1};
    step(); step();

    // Reset state
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_vga_write", vga_write, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_overrun", overrun, 0);
    check("rst_x_out", x_out, 0);

    // 1. Empty frame
    reset = 1'b0; req = 4'b0000; frame_tick = 1'b1;
    step(); frame_tick = 1'b0;
    check("empty_c1_busy", busy, 1);
    check("empty_c1_frame_done", frame_done, 0);
    check("empty_c1_grant", grant, 0);
    step();
    check("empty_c2_busy", busy, 1);
    check("empty_c2_frame_done", frame_done, 1);
    check("empty_c2_grant", grant, 0);
    step();
    check("empty_c3_busy", busy, 0);
    check("empty_c3_frame_done", frame_done, 0);

    // 2. Single plotter, done on its 560th grant cycle
    req = 4'b0100; frame_tick = 1'b1;
    step(); frame_tick = 1'b0;
    check("single_scan_grant", grant, 0);
    step();
    gcnt = 0;
    for (int i = 0; i < 560; i++) begin
      if (grant == 4'b0100 && vga_write) gcnt++;
      if (i == 0) begin
        check("single_x", x_out, 300);
        check("single_y", y_out, 33);
        check("single_colour", colour_out, 5);
      end
      if (i == 100) begin
        x_in[26:18] = 9'd257;
        #1 check("single_x_track", x_out, 257);
      end
      if (i == 559) done = 4'b0100;
      step();
    end
    done = 4'b0;
    x_in[26:18] = 9'd300;
    check("single_grant_cycles", gcnt, 560);
    check("single_gap_grant", grant, 0);
    check("single_gap_vga_write", vga_write, 0);
    check("single_gap_x", x_out, 0);
    step();
    check("single_scan_frame_done", frame_done, 0);
    step();
    check("single_finish_frame_done", frame_done, 1);
    step();
    check("single_idle_busy", busy, 0);

    // 3. Ordering: 0001, 0010, 1000 with GAP+SCAN between
    exp3 = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h2, 4'h2, 4'h0, 4'h0,
             4'h8, 4'h8, 4'h0, 4'h0, 4'h0};
    run_frame(4'b1011, 2);
    check("order_len", rec_n, 14);
    for (int k = 0; k < 14; k++) check($sformatf("order_cyc%0d", k), rec[k], exp3[k]);

    // 4. Timeout after exactly 1023 cycles
    check("pre_timeout_err", timeout_err, 0);
    run_frame(4'b0001, 0);
    gcnt = 0;
    for (int k = 0; k < rec_n; k++) if (rec[k] == 4'b0001) gcnt++;
    check("timeout_grant_cycles", gcnt, 1023);
    check("timeout_len", rec_n, 1027);
    check("timeout_err_set", timeout_err, 1);
    run_frame(4'b0010, 3);
    check("after_timeout_len", rec_n, 7);
    check("after_timeout_grant", rec[1], 4'b0010);
    check("timeout_err_sticky", timeout_err, 1);

    // 5. Overrun and stray done
    req = 4'b0001; frame_tick = 1'b1;
    step(); frame_tick = 1'b0;
    step();
    check("ovr_grant", grant, 4'b0001);
    check("ovr_before", overrun, 0);
    done = 4'b1000; frame_tick = 1'b1;
    step();
    done = 4'b0; frame_tick = 1'b0;
    check("stray_done_grant", grant, 4'b0001);
    check("ovr_set", overrun, 1);
    done = 4'b0001;
    step(); done = 4'b0;
    check("ovr_gap_grant", grant, 0);
    step(); step();
    check("ovr_finish", frame_done, 1);
    step();
    check("ovr_idle_busy", busy, 0);
    step();
    check("ovr_no_second_frame", busy, 0);
    check("ovr_sticky", overrun, 1);

    // 6. Reset during grant of plotter 1
    req = 4'b0010; frame_tick = 1'b1;
    step(); frame_tick = 1'b0;
    step();
    check("rst_mid_grant_before", grant, 4'b0010);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_mid_grant", grant, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_vga_write", vga_write, 0);
    check("rst_mid_timeout_err", timeout_err, 0);
    check("rst_mid_overrun", overrun, 0);
    run_frame(4'b0011, 1);
    check("restart_len", rec_n, 8);
    check("restart_first", rec[1], 4'b0001);
    check("restart_second", rec[4], 4'b0010);

    // done on the very cycle the timeout would fire: done wins
    run_frame(4'b0001, 1023);
    check("done_vs_timeout_len", rec_n, 1027);
    check("done_vs_timeout_err", timeout_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/plot_scheduler.md
Name: plot_scheduler

Overview:
- Frame-level scheduler that shares the single VGA adapter write port among N_REQ sprite plotters (user, alien block, bullets, ...).
- On each frame tick it snapshots which plotters want to draw. It grants them one at a time in ascending index order, so a higher index is drawn on top.
- While a plotter is granted, its x/y/colour go to the VGA adapter; the scheduler waits for that plotter's done, or aborts it on timeout.
- Sits between the per-sprite FSMs and the VGA adapter; each grant bit drives that plotter's enable input.

Parameters:
- N_REQ, 4, number of sprite plotters sharing the VGA port (2..8).
- TIMEOUT, 1023, maximum cycles a grant may be held before it is forcibly revoked.
- TW, 10, width of the timeout counter; must satisfy 2^TW > TIMEOUT.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous reset, active-high.
- frame_tick  in  1  one-cycle pulse that starts a frame.
- req  in  N_REQ  per-plotter draw request; sampled only on an accepted frame_tick.
- done  in  N_REQ  per-plotter completion pulse.
- x_in  in  9*N_REQ  plotter x positions; plotter i uses bits [9i+8:9i].
- y_in  in  8*N_REQ  plotter y positions; plotter i uses bits [8i+7:8i].
- colour_in  in  3*N_REQ  plotter colours; plotter i uses bits [3i+2:3i].
- grant  out  N_REQ  one-hot plotter enable; all zero when nothing is granted.
- x_out  out  9  x to the VGA adapter.
- y_out  out  8  y to the VGA adapter.
- colour_out  out  3  colour to the VGA adapter.
- vga_write  out  1  writeEn to the VGA adapter.
- busy  out  1  high whenever state is not IDLE.
- frame_done  out  1  one-cycle pulse at the end of a frame.
- timeout_err  out  1  sticky; set when any grant times out.
- overrun  out  1  sticky; set when frame_tick arrives while busy.

Behaviour:
- Reset (synchronous, has priority over everything): state=IDLE, pending=0, sel=0, timer=0. All outputs are 0, including both sticky flags. Reset asserted mid-grant drops grant on the next edge.
- States: IDLE, SCAN, GRANT, GAP, FINISH. Registers: pending[N_REQ], sel (index), timer[TW].
- IDLE:
  - If frame_tick=1: pending<=req and go to SCAN.
  - Otherwise stay in IDLE.
- SCAN (one cycle):
  - If pending==0, go to FINISH.
  - Otherwise sel<=lowest set index of pending, clear that pending bit, timer<=0, and go to GRANT.
- GRANT:
  - grant[sel]=1 and vga_write=1.
  - x_out, y_out and colour_out = slice sel of x_in, y_in and colour_in, combinationally.
  - timer increments every cycle.
  - If done[sel]=1: go to GAP. The done cycle itself still has vga_write=1, so the plotter's final pixel is written.
  - Else if timer==TIMEOUT-1: timeout_err<=1 and go to GAP, so the grant lasts exactly TIMEOUT cycles.
  - If done and timeout occur in the same cycle, done wins and timeout_err is not set.
- GAP (one cycle): grant=0 and vga_write=0, letting the plotter fall back to its wait state. Then go to SCAN.
- FINISH (one cycle): frame_done=1, then go to IDLE.
- Outside GRANT: grant=0, vga_write=0, and x_out, y_out, colour_out are all 0.
- done bits from non-granted plotters are ignored. A done[sel] in a cycle where the state is not GRANT is also ignored.
- frame_tick in any state other than IDLE is dropped, not queued, and sets overrun<=1.
- req changes after the snapshot have no effect until the next accepted frame.
- Timing for an empty frame: tick at edge 0, then SCAN at cycle 1, FINISH at cycle 2 with frame_done=1, and IDLE at cycle 3.
- Per-grant overhead is 2 cycles (SCAN + GAP) in addition to the plotter's own cycles.
- No combinational path from req to any output. grant depends only on registered state.

Test Plan:
1. Empty frame: reset, then frame_tick with req=0000. Expect busy=1 for cycles 1-2, frame_done=1 exactly at cycle 2, and grant never asserted.
2. Single plotter: req=0100, and a plotter model pulses done 560 cycles after grant rises.
   - Expect grant=0100 for 560 cycles and vga_write high for the same 560 cycles.
   - Expect x/y/colour_out to track slice 2 of the inputs.
   - Expect frame_done 2 cycles after grant falls.
3. Order and overlay: req=1011. Expect grants in the order 0001, 0010, 1000, each separated by exactly one zero-grant GAP cycle plus one SCAN cycle. Plotter 2 is never granted.
4. Timeout: req=0001, and the plotter never asserts done.
   - Expect grant held exactly TIMEOUT=1023 cycles, then timeout_err=1 (sticky), then frame_done.
   - A following frame with a well-behaved plotter completes normally with timeout_err still 1.
5. Overrun and stray done: frame_tick pulsed mid-GRANT → overrun=1 and no second frame starts after frame_done. A done[3] pulse while grant=0001 → no state change.
6. Reset mid-operation: assert reset during GRANT of plotter 1. Next cycle: grant=0, busy=0, all flags 0. A new frame_tick restarts from index 0.
